// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_e  : controller state (IDLE / RUN / PAUSE)
//   DIGIT_W  : bits per BCD digit
//   BCD_MAX  : largest value a decade digit holds before returning to 0
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the button front end, the stopwatch
// controller and the display driver.
//   start, stop, clear, lap : single-cycle command pulses (master -> slave)
//   digits                  : live BCD count, digit 0 in [3:0]
//   running                 : high while counting
//   wrapped                 : sticky full-scale rollover flag
//   lap_digits, lap_valid   : last captured count and its one-cycle strobe
interface stopwatch_ctrl_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) ();

    logic                            start;
    logic                            stop;
    logic                            clear;
    logic                            lap;
    logic [DIGIT_W*NUM_DIGITS-1:0]   digits;
    logic                            running;
    logic                            wrapped;
    logic [DIGIT_W*NUM_DIGITS-1:0]   lap_digits;
    logic                            lap_valid;

    modport master (
        output start, stop, clear, lap,
        input  digits, running, wrapped, lap_digits, lap_valid
    );

    modport slave (
        input  start, stop, clear, lap,
        output digits, running, wrapped, lap_digits, lap_valid
    );

endinterface

// File: rtl/bcd_digit.sv
// One decade counter of the stopwatch chain.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous zero, wins over en
//   en         : advance by one this edge
//   q          : current digit value, always 0..9
//   carry      : en while at 9, i.e. this digit rolls over on this edge
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: tick prescaler feeding a cascade of BCD digits,
// with a sticky wrap flag and a lap-capture register.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : stopwatch_ctrl_if slave (command pulses in, count/status out)
// Parameters:
//   TICK_DIV   : clk cycles per count increment (>= 1)
//   NUM_DIGITS : number of cascaded BCD digits (>= 1)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    stopwatch_ctrl_if.slave    bus
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W = DIGIT_W * NUM_DIGITS;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               wrapped_q, wrapped_d;
    logic [CNT_W-1:0]   lap_q, lap_d;
    logic               lap_valid_q, lap_valid_d;
    logic               tick;
    logic [CNT_W-1:0]   digits;
    // en_chain[k] enables digit k; en_chain[NUM_DIGITS] flags full-scale rollover.
    logic [NUM_DIGITS:0] en_chain;

    // Increments follow the current state, so a stop on a terminal-tick
    // cycle still commits that increment.
    assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (bus.start) begin
            if (state_q != RUN) begin
                state_d = RUN;
            end
        end
    end

    // Prescaler freezes in PAUSE so a resume finishes the partial period.
    always_comb begin
        pre_d = pre_q;
        if (bus.clear) begin
            pre_d = '0;
        end else begin
            unique case (state_q)
                RUN:     pre_d = tick ? '0 : pre_q + 1'b1;
                PAUSE:   pre_d = pre_q;
                default: pre_d = '0;
            endcase
        end
    end

    assign en_chain[0] = tick && !bus.clear;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (bus.clear),
            .en    (en_chain[i]),
            .q     (digits[i*DIGIT_W +: DIGIT_W]),
            .carry (en_chain[i+1])
        );
    end

    always_comb begin
        wrapped_d   = wrapped_q | en_chain[NUM_DIGITS];
        lap_d       = bus.lap ? digits : lap_q;
        lap_valid_d = bus.lap;
        if (bus.clear) begin
            wrapped_d   = 1'b0;
            lap_d       = '0;
            lap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            wrapped_q   <= 1'b0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            wrapped_q   <= wrapped_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign bus.digits     = digits;
    assign bus.running    = (state_q == RUN);
    assign bus.wrapped    = wrapped_q;
    assign bus.lap_digits = lap_q;
    assign bus.lap_valid  = lap_valid_q;

endmodule
